// File: rtl/apb3_master.sv
// APB3 requester: takes one command at a time on a valid/ready port, runs SETUP/ACCESS
// on the APB bus and returns a one-cycle response with read data and error/timeout flags.
module apb3_master #(
   parameter int N_BIT_DATA     = 32,
   parameter int N_BIT_ADDRESS  = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [N_BIT_ADDRESS-1:0] req_addr,
   input  logic [N_BIT_DATA-1:0]    req_wdata,
   output logic                     rsp_valid,
   output logic [N_BIT_DATA-1:0]    rsp_rdata,
   output logic                     rsp_error,
   output logic                     rsp_timeout,
   output logic                     PSEL,
   output logic                     PENABLE,
   output logic                     PWRITE,
   output logic [N_BIT_ADDRESS-1:0] PADDR,
   output logic [N_BIT_DATA-1:0]    PWDATA,
   input  logic [N_BIT_DATA-1:0]    PRDATA,
   input  logic                     PREADY,
   input  logic                     PSLVERR
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   // Timeout fires on the edge where the count would reach TIMEOUT_CYCLES.
   localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       w_accept;
   logic                       w_done;
   logic                       w_timeout;
   logic [CW-1:0]              r_wait_cnt;
   logic                       r_psel;
   logic                       r_penable;
   logic                       r_pwrite;
   logic [N_BIT_ADDRESS-1:0]   r_paddr;
   logic [N_BIT_DATA-1:0]      r_pwdata;
   logic                       r_rsp_valid;
   logic [N_BIT_DATA-1:0]      r_rsp_rdata;
   logic                       r_rsp_error;
   logic                       r_rsp_timeout;

   assign req_ready   = (r_state == ST_IDLE) && !PRESET;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_error   = r_rsp_error;
   assign rsp_timeout = r_rsp_timeout;

   // Next-state logic; normal completion takes priority over timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_SETUP;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_wait_cnt == C_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_ACCESS;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, wait counter and APB bus registers.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state    <= ST_IDLE;
         r_wait_cnt <= '0;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_psel    <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
         r_penable <= (w_state_nxt == ST_ACCESS);
         if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
         end else if ((r_state == ST_ACCESS) && !PREADY) begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
         end else begin
            r_wait_cnt <= r_wait_cnt;
         end
         if (w_accept) begin
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
         end else begin
            r_pwrite <= r_pwrite;
            r_paddr  <= r_paddr;
            r_pwdata <= r_pwdata;
         end
      end
   end

   // One-cycle response strobe; payload fields are zero whenever the strobe is low.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_error   <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_rsp_valid   <= w_done || w_timeout;
         r_rsp_rdata   <= (w_done && !r_pwrite) ? PRDATA : '0;
         r_rsp_error   <= (w_done && PSLVERR) || w_timeout;
         r_rsp_timeout <= w_timeout;
      end
   end

endmodule

// File: tb/tb_apb3_master.sv
// Self-checking bench for apb3_master: directed transfers, a scoreboard queue of expected
// responses and a monitor that pops and compares whenever rsp_valid is seen.
module tb_apb3_master;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int TO = 4;

   logic          PCLK;
   logic          PRESET;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_error;
   logic          rsp_timeout;
   logic          PSEL;
   logic          PENABLE;
   logic          PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA;
   logic          PREADY;
   logic          PSLVERR;

   apb3_master #(
      .N_BIT_DATA    (DW),
      .N_BIT_ADDRESS (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_error  (rsp_error),
      .rsp_timeout(rsp_timeout),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
      int            cyc;
   } exp_t;

   exp_t          sb[$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            psel_cnt = 0;
   int            pen_cnt  = 0;
   int            slv_wait = 0;
   logic [DW-1:0] slv_rdata = '0;
   logic          slv_err = 1'b0;
   logic          slv_err_setup = 1'b0;
   logic          exp_write = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   initial begin
      forever begin
         @(posedge PCLK);
         cyc++;
      end
   end

   // Slave model plus bus-stability checks, evaluated away from the active edge.
   initial begin
      int acc_n;
      acc_n   = 0;
      PREADY  = 1'b0;
      PRDATA  = '0;
      PSLVERR = 1'b0;
      forever begin
         @(negedge PCLK);
         if (PSEL) begin
            psel_cnt++;
            chk("req_ready_busy", req_ready, 1'b0);
            chk("paddr_stable", PADDR, exp_addr);
            chk("pwrite_stable", PWRITE, exp_write);
            chk("pwdata_stable", PWDATA, exp_wdata);
         end
         if (PSEL && PENABLE) begin
            pen_cnt++;
            PREADY = (acc_n == slv_wait);
            acc_n++;
         end else begin
            PREADY = 1'b0;
            acc_n  = 0;
         end
         PRDATA  = PREADY ? slv_rdata : 32'hBAD0_0000;
         PSLVERR = PREADY ? slv_err : ((PSEL && !PENABLE) ? slv_err_setup : 1'b0);
      end
   end

   // Response monitor: pops the scoreboard on every rsp_valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge PCLK);
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_error", rsp_error, e.err);
               chk("rsp_timeout", rsp_timeout, e.to);
               chk("rsp_cycle", cyc, e.cyc);
            end
         end else begin
            chk("rsp_idle_zero", {rsp_rdata, rsp_error, rsp_timeout}, 64'd0);
         end
      end
   end

   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit push, input logic [DW-1:0] er, input logic ee,
                        input logic et, input int lat, output int acc);
      int   n;
      exp_t e;
      n         = 0;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      chk("req_ready_wait", req_ready, 1'b1);
      acc       = cyc;
      exp_write = w;
      exp_addr  = a;
      exp_wdata = d;
      psel_cnt  = 0;
      pen_cnt   = 0;
      if (push) begin
         e.rdata = er;
         e.err   = ee;
         e.to    = et;
         e.cyc   = acc + lat;
         sb.push_back(e);
      end
      @(negedge PCLK);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      chk("drain", sb.size(), 0);
      sb.delete();
      @(negedge PCLK);
   endtask

   initial begin
      int a0, a1, a2, ax;
      PRESET    = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge PCLK);
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_pwrite", PWRITE, 1'b0);
      chk("rst_paddr", PADDR, 4'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("idle_req_ready", req_ready, 1'b1);

      // Zero-wait write.
      slv_wait = 0;
      issue(1'b1, 4'h3, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 1'b0, 3, ax);
      drain();
      chk("w0_psel_cycles", psel_cnt, 2);
      chk("w0_penable_cycles", pen_cnt, 1);

      // Read with three wait states (PREADY arrives on the last pre-timeout cycle).
      slv_wait  = 3;
      slv_rdata = 32'h1234_5678;
      issue(1'b0, 4'h5, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 6, ax);
      drain();
      chk("r3_psel_cycles", psel_cnt, 5);
      chk("r3_penable_cycles", pen_cnt, 4);

      // Slave error on completion; PSLVERR in SETUP must be ignored.
      slv_wait      = 0;
      slv_rdata     = 32'hCAFE_F00D;
      slv_err       = 1'b1;
      slv_err_setup = 1'b1;
      issue(1'b0, 4'hA, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 3, ax);
      drain();
      slv_err = 1'b0;
      issue(1'b1, 4'hB, 32'h0BAD_1DEA, 1'b1, 32'h0, 1'b0, 1'b0, 3, ax);
      drain();
      slv_err_setup = 1'b0;

      // Timeout with PREADY held low.
      slv_wait = 1000;
      issue(1'b0, 4'h7, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1, 6, ax);
      drain();
      chk("to_psel_cycles", psel_cnt, 5);
      chk("to_penable_cycles", pen_cnt, 4);

      // Write whose PREADY lands exactly on the timeout cycle.
      slv_wait = 3;
      issue(1'b1, 4'h9, 32'h0000_55AA, 1'b1, 32'h0, 1'b0, 1'b0, 6, ax);
      drain();

      // Reset on the second wait cycle: outputs drop at once, no response follows.
      slv_wait = 1000;
      issue(1'b0, 4'h2, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 0, ax);
      repeat (2) @(negedge PCLK);
      chk("mid_penable_before_rst", PENABLE, 1'b1);
      PRESET = 1'b1;
      #1;
      chk("mid_rst_psel", PSEL, 1'b0);
      chk("mid_rst_penable", PENABLE, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_req_ready", req_ready, 1'b0);
      repeat (2) @(negedge PCLK);
      PRESET   = 1'b0;
      slv_wait = 0;
      repeat (3) @(negedge PCLK);
      slv_rdata = 32'h89AB_CDEF;
      issue(1'b0, 4'h4, 32'h0, 1'b1, 32'h89AB_CDEF, 1'b0, 1'b0, 3, ax);
      drain();

      // Back-to-back writes with req_valid kept high.
      issue(1'b1, 4'h1, 32'h1111_1111, 1'b1, 32'h0, 1'b0, 1'b0, 3, a0);
      issue(1'b1, 4'h2, 32'h2222_2222, 1'b1, 32'h0, 1'b0, 1'b0, 3, a1);
      issue(1'b1, 4'h3, 32'h3333_3333, 1'b1, 32'h0, 1'b0, 1'b0, 3, a2);
      chk("b2b_gap01", a1 - a0, 3);
      chk("b2b_gap12", a2 - a1, 3);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
